// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through receive FIFO with a registered head entry.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_Clock,
  input  logic             RESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign wr_nxt  = wr_ptr + PW'(do_push);
  assign rd_nxt  = rd_ptr + PW'(do_pop);

  // Head register looks ahead at the post-update pointers so it tracks the FIFO exactly.
  always_ff @(posedge i_Clock) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      valid  <= (wr_nxt != rd_nxt);
      if (wr_nxt == rd_nxt)
        rdata <= '0;
      else if (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0]))
        rdata <= wdata;
      else
        rdata <= mem[rd_nxt[AW-1:0]];
    end
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: line synchronizer, majority-vote bit FSM,
// error/break detection and a small FWFT receive FIFO.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 235,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 RESET,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  input  logic                 i_Clear_Err,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Break
);

  localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned MID     = (CLKS_PER_BIT - 1) / 2;
  localparam int unsigned ENTRY_W = DATA_BITS + 2;
  localparam int unsigned IDX_W   = 4;

  logic                 rx_meta, rx_sync;
  rx_state_t            state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp_a, samp_b;
  logic                 par_err, frame_err, any_one;
  logic                 push;
  logic [ENTRY_W-1:0]   push_entry, head;
  logic                 fifo_full, fifo_empty, pop;
  logic                 bit_val, at_decide, cnt_wrap;

  assign bit_val   = maj3(samp_a, samp_b, rx_sync);
  assign at_decide = (cnt == CNT_W'(MID + 1));
  assign cnt_wrap  = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign pop       = !fifo_empty && i_Rx_Ready;

  always_ff @(posedge i_Clock) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // Bit-timing FSM; the counter phase is anchored to the first low sample of the start bit.
  always_ff @(posedge i_Clock) begin
    if (RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      samp_a     <= 1'b1;
      samp_b     <= 1'b1;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
      any_one    <= 1'b0;
      push       <= 1'b0;
      push_entry <= '0;
      o_Break    <= 1'b0;
    end else begin
      push    <= 1'b0;
      o_Break <= 1'b0;
      if (state != IDLE && state != WAIT_HIGH) begin
        cnt <= cnt_wrap ? '0 : cnt + CNT_W'(1);
        if (cnt == CNT_W'(MID - 1)) samp_a <= rx_sync;
        if (cnt == CNT_W'(MID))     samp_b <= rx_sync;
      end
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) begin
            state     <= START;
            cnt       <= CNT_W'(1);
            bit_idx   <= '0;
            frame_err <= 1'b0;
            par_err   <= 1'b0;
            any_one   <= 1'b0;
          end
        end
        START: begin
          if (at_decide) begin
            if (bit_val) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (at_decide) begin
            shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
            any_one <= any_one | bit_val;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end
        uart_pkg::PARITY: begin
          if (at_decide) begin
            any_one <= any_one | bit_val;
            par_err <= (PARITY == PAR_ODD) ? ~(bit_val ^ (^shreg)) : (bit_val ^ (^shreg));
            state   <= STOP;
          end
        end
        STOP: begin
          // Frame completes at the mid of the last stop bit; break frames are not queued.
          if (at_decide) begin
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              state <= WAIT_HIGH;
              cnt   <= '0;
              if (!(any_one | bit_val)) begin
                o_Break <= 1'b1;
              end else begin
                push       <= 1'b1;
                push_entry <= {frame_err | ~bit_val, par_err, shreg};
              end
            end else begin
              bit_idx   <= bit_idx + IDX_W'(1);
              frame_err <= frame_err | ~bit_val;
              any_one   <= any_one | bit_val;
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky overrun; a new drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge i_Clock) begin
    if (RESET)
      o_Overrun <= 1'b0;
    else if (push && fifo_full && !pop)
      o_Overrun <= 1'b1;
    else if (i_Clear_Err)
      o_Overrun <= 1'b0;
  end

  uart_rx_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_Clock(i_Clock),
    .RESET  (RESET),
    .push   (push),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head),
    .valid  (o_Rx_Valid),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign o_Rx_Data    = head[DATA_BITS-1:0];
  assign o_Parity_Err = head[DATA_BITS];
  assign o_Frame_Err  = head[DATA_BITS+1];

endmodule
